// File: rtl/mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter_pkg
//   Shared encodings for the IF/MEM memory-port arbiter: FSM state codes,
//   grant owner codes, the full-word byte-enable constant used for fetches,
//   and the round-robin grant selection helper.
//
//   Contents:
//     arb_state_t  : ARB_IDLE, ARB_IF_BUSY, ARB_MEM_BUSY, ARB_DONE
//     arb_grant_t  : ARB_GRANT_IF, ARB_GRANT_MEM
//     SEL_WORD     : byte enables for a full 32-bit fetch
//     pick_grant() : winner selection among pending requests in IDLE
// -----------------------------------------------------------------------------
package mem_port_arbiter_pkg;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_IF_BUSY  = 2'd1,
      ARB_MEM_BUSY = 2'd2,
      ARB_DONE     = 2'd3
   } arb_state_t;

   typedef enum logic {
      ARB_GRANT_IF  = 1'b0,
      ARB_GRANT_MEM = 1'b1
   } arb_grant_t;

   localparam logic [3:0] SEL_WORD = 4'hF;

   // Round-robin: on a conflict the side that was NOT served last wins.
   // Only meaningful when at least one request is high.
   function automatic arb_grant_t pick_grant(
      input logic       if_req,
      input logic       mem_req,
      input arb_grant_t last_grant
   );
      if (if_req && mem_req) begin
         return (last_grant == ARB_GRANT_IF) ? ARB_GRANT_MEM : ARB_GRANT_IF;
      end else if (mem_req) begin
         return ARB_GRANT_MEM;
      end else begin
         return ARB_GRANT_IF;
      end
   endfunction

endpackage

// File: rtl/mem_port_arbiter_watchdog.sv
// -----------------------------------------------------------------------------
// arb_watchdog
//   Bus transaction watchdog for the memory-port arbiter. Counts BUSY cycles
//   since the last grant and flags expiry on the TIMEOUT_CYCLES-th busy cycle,
//   so the arbiter can abandon a transaction whose ack never arrives.
//   Instantiated by mem_port_arbiter only when ARB_TIMEOUT_EN is defined.
//
//   Ports:
//     clk       in   clock
//     rst       in   asynchronous reset, active-high
//     i_clear   in   grant made this cycle; restart the count
//     i_busy    in   arbiter is in a BUSY state this cycle
//     o_expire  out  this busy cycle is the last one allowed (combinational)
// -----------------------------------------------------------------------------
module arb_watchdog #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic clk,
   input  logic rst,
   input  logic i_clear,
   input  logic i_busy,
   output logic o_expire
);

   // Wide enough to hold TIMEOUT_CYCLES itself: the count may step one past
   // the expiry value when ack and expiry land on the same cycle.
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (i_clear) begin
         r_cnt <= '0;
      end else if (i_busy) begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   // r_cnt holds the number of busy cycles already elapsed, so the value
   // TIMEOUT_CYCLES-1 marks the TIMEOUT_CYCLES-th busy cycle.
   assign o_expire = i_busy && (r_cnt == LAST_CNT);

endmodule

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//   Shares one single-ported memory bus between the IF-stage fetch and the
//   MEM-stage load/store. Each granted request becomes one bus transaction
//   (bus_req held until bus_ack); the read data is returned to the owner with
//   a one-cycle rdy pulse. Conflicts are resolved round-robin. Every
//   transaction ends with a single DONE cycle so the pipeline can retire the
//   request before requests are sampled again in IDLE.
//
//   A branch redirect (if_flush) during an IF transaction marks it dropped:
//   the bus access still completes, but no if_rdy is issued and if_rdata is
//   left unchanged.
//
//   Optional feature macro: ARB_TIMEOUT_EN
//     Defined   : a watchdog abandons a transaction after TIMEOUT_CYCLES busy
//                 cycles without bus_ack; bus_err pulses, owner gets rdata=0
//                 and an rdy pulse (unless dropped).
//     Undefined : BUSY waits indefinitely for bus_ack; bus_err tied 0.
//
//   Ports:
//     clk, rst                     clock, async active-high reset
//     if_req/if_addr/if_flush      fetch request, pc, branch redirect
//     if_rdy/if_rdata              fetch data valid pulse, instruction
//     mem_req/we/sel/addr/wdata    load/store request
//     mem_rdy/mem_rdata            data access done pulse, load data
//     stallreq_if/stallreq_mem     combinational stall requests
//     bus_req/we/sel/addr/wdata    memory bus command (registered)
//     bus_ack/bus_rdata            memory bus completion and read data
//     bus_err                      watchdog timeout pulse
// -----------------------------------------------------------------------------
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic              clk,
   input  logic              rst,
   // fetch side
   input  logic              if_req,
   input  logic [ADDR_W-1:0] if_addr,
   input  logic              if_flush,
   output logic              if_rdy,
   output logic [DATA_W-1:0] if_rdata,
   // load/store side
   input  logic              mem_req,
   input  logic              mem_we,
   input  logic [3:0]        mem_sel,
   input  logic [ADDR_W-1:0] mem_addr,
   input  logic [DATA_W-1:0] mem_wdata,
   output logic              mem_rdy,
   output logic [DATA_W-1:0] mem_rdata,
   // stall requests to stall_control
   output logic              stallreq_if,
   output logic              stallreq_mem,
   // memory bus
   output logic              bus_req,
   output logic              bus_we,
   output logic [3:0]        bus_sel,
   output logic [ADDR_W-1:0] bus_addr,
   output logic [DATA_W-1:0] bus_wdata,
   input  logic              bus_ack,
   input  logic [DATA_W-1:0] bus_rdata,
   output logic              bus_err
);

   arb_state_t  r_state;
   arb_state_t  w_next_state;
   arb_grant_t  r_last_grant;
   arb_grant_t  w_owner;
   logic        r_drop;

   logic        w_grant_if;
   logic        w_grant_mem;
   logic        w_complete;    // bus_ack accepted in a BUSY state
   logic        w_timeout;     // watchdog gave up on the transaction
   logic        w_finish;      // transaction ends this cycle (ack or timeout)
   logic        w_set_drop;
   logic        w_drop_eff;
   logic        w_expire;
   logic [DATA_W-1:0] w_fin_data;

   // ---------------------------------------------------------------------------
   // State register
   // ---------------------------------------------------------------------------
   // NOTE: clocked state uses non-blocking assignments so every flop samples
   // the pre-edge value of its inputs regardless of block ordering.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= ARB_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ---------------------------------------------------------------------------
   // Next-state and transaction control
   // ---------------------------------------------------------------------------
   // NOTE: every output of this block is given a default first, so no path
   // through the case can leave a signal unassigned and infer a latch.
   always_comb begin
      w_next_state = r_state;
      w_grant_if   = 1'b0;
      w_grant_mem  = 1'b0;
      w_complete   = 1'b0;
      w_timeout    = 1'b0;
      w_set_drop   = 1'b0;

      case (r_state)
         ARB_IDLE: begin
            if (if_req || mem_req) begin
               if (pick_grant(if_req, mem_req, r_last_grant) == ARB_GRANT_MEM) begin
                  w_grant_mem  = 1'b1;
                  w_next_state = ARB_MEM_BUSY;
               end else begin
                  w_grant_if   = 1'b1;
                  // A redirect in the grant cycle already makes this fetch stale.
                  w_set_drop   = if_flush;
                  w_next_state = ARB_IF_BUSY;
               end
            end
         end

         ARB_IF_BUSY: begin
            w_set_drop = if_flush;
            if (bus_ack) begin
               w_complete   = 1'b1;
               w_next_state = ARB_DONE;
            end else if (w_expire) begin
               w_timeout    = 1'b1;
               w_next_state = ARB_DONE;
            end
         end

         ARB_MEM_BUSY: begin
            if (bus_ack) begin
               w_complete   = 1'b1;
               w_next_state = ARB_DONE;
            end else if (w_expire) begin
               w_timeout    = 1'b1;
               w_next_state = ARB_DONE;
            end
         end

         ARB_DONE: begin
            // One dead cycle: requests are ignored so the pipeline can drop
            // the req that was just answered before IDLE samples again.
            w_next_state = ARB_IDLE;
         end

         default: begin
            w_next_state = ARB_IDLE;
         end
      endcase
   end

   assign w_owner    = (r_state == ARB_MEM_BUSY) ? ARB_GRANT_MEM : ARB_GRANT_IF;
   assign w_finish   = w_complete | w_timeout;
   // A flush arriving in the same cycle as the ack still cancels the fetch.
   assign w_drop_eff = r_drop | ((r_state == ARB_IF_BUSY) & if_flush);
   // A timed-out transaction returns zero data.
   assign w_fin_data = w_complete ? bus_rdata : '0;

   // ---------------------------------------------------------------------------
   // Bus command, response data and round-robin history
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req      <= 1'b0;
         bus_we       <= 1'b0;
         bus_sel      <= '0;
         bus_addr     <= '0;
         bus_wdata    <= '0;
         if_rdy       <= 1'b0;
         if_rdata     <= '0;
         mem_rdy      <= 1'b0;
         mem_rdata    <= '0;
         r_last_grant <= ARB_GRANT_IF;
      end else begin
         if_rdy  <= 1'b0;
         mem_rdy <= 1'b0;

         if (w_grant_if) begin
            bus_req   <= 1'b1;
            bus_we    <= 1'b0;
            bus_sel   <= SEL_WORD;
            bus_addr  <= if_addr;
            bus_wdata <= '0;
         end else if (w_grant_mem) begin
            bus_req   <= 1'b1;
            bus_we    <= mem_we;
            bus_sel   <= mem_sel;
            bus_addr  <= mem_addr;
            bus_wdata <= mem_wdata;
         end

         // Command fields are left as-is after completion; only bus_req
         // carries meaning outside a transaction.
         if (w_finish) begin
            bus_req      <= 1'b0;
            r_last_grant <= w_owner;
            if (w_owner == ARB_GRANT_MEM) begin
               mem_rdata <= w_fin_data;
               mem_rdy   <= 1'b1;
            end else if (!w_drop_eff) begin
               if_rdata  <= w_fin_data;
               if_rdy    <= 1'b1;
            end
         end
      end
   end

   // Drop flag: set by a redirect, consumed by the end of the IF transaction.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_drop <= 1'b0;
      end else if (w_finish) begin
         r_drop <= 1'b0;
      end else if (w_set_drop) begin
         r_drop <= 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Stall requests: hold the stage until its rdy pulse
   // ---------------------------------------------------------------------------
   assign stallreq_if  = if_req  & ~if_rdy;
   assign stallreq_mem = mem_req & ~mem_rdy;

   // ---------------------------------------------------------------------------
   // Optional bus watchdog
   // ---------------------------------------------------------------------------
`ifdef ARB_TIMEOUT_EN
   logic w_busy;
   logic r_bus_err;

   assign w_busy = (r_state == ARB_IF_BUSY) || (r_state == ARB_MEM_BUSY);

   arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk      (clk),
      .rst      (rst),
      .i_clear  (w_grant_if | w_grant_mem),
      .i_busy   (w_busy),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_bus_err <= 1'b0;
      end else begin
         r_bus_err <= w_timeout;
      end
   end

   assign bus_err = r_bus_err;
`else
   logic w_unused_timeout;

   assign w_expire         = 1'b0;
   assign bus_err          = 1'b0;
   assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//   Scoreboard bench for mem_port_arbiter. Stimulus pushes the expected bus
//   commands and rdy responses into queues; independent monitors pop and
//   compare when the DUT raises bus_req or an rdy pulse. A behavioural bus
//   slave answers with a programmable ack latency and queued read data.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;
   localparam int TO_CYC = 8;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic              if_req = 1'b0, if_flush = 1'b0;
   logic [ADDR_W-1:0] if_addr = '0;
   logic              if_rdy;
   logic [DATA_W-1:0] if_rdata;
   logic              mem_req = 1'b0, mem_we = 1'b0;
   logic [3:0]        mem_sel = 4'hF;
   logic [ADDR_W-1:0] mem_addr = '0;
   logic [DATA_W-1:0] mem_wdata = '0;
   logic              mem_rdy;
   logic [DATA_W-1:0] mem_rdata;
   logic              stallreq_if, stallreq_mem;
   logic              bus_req, bus_we, bus_err;
   logic [3:0]        bus_sel;
   logic [ADDR_W-1:0] bus_addr;
   logic [DATA_W-1:0] bus_wdata;
   logic              bus_ack = 1'b0;
   logic [DATA_W-1:0] bus_rdata = '0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO_CYC)
   ) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
      .if_rdy(if_rdy), .if_rdata(if_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_sel(mem_sel),
      .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdy(mem_rdy), .mem_rdata(mem_rdata),
      .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem),
      .bus_req(bus_req), .bus_we(bus_we), .bus_sel(bus_sel),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata), .bus_err(bus_err)
   );

   typedef struct {
      bit          is_mem;
      logic [31:0] rdata;
      bit          chk_data;
      bit          err;
   } resp_t;

   typedef struct {
      logic [31:0] addr;
      bit          we;
      logic [3:0]  sel;
      logic [31:0] wdata;
   } bus_t;

   resp_t       resp_q[$];
   bus_t        bus_q[$];
   logic [31:0] rd_q[$];

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [95:0] got, input logic [95:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic push_bus(input logic [31:0] a, input bit we, input logic [3:0] sel,
                           input logic [31:0] wd);
      bus_t b;
      b.addr = a; b.we = we; b.sel = sel; b.wdata = wd;
      bus_q.push_back(b);
   endtask

   task automatic push_resp(input bit is_mem, input logic [31:0] rd, input bit chk, input bit err);
      resp_t r;
      r.is_mem = is_mem; r.rdata = rd; r.chk_data = chk; r.err = err;
      resp_q.push_back(r);
   endtask

   // ---------------- bus slave ----------------
   int slave_lat = 1;
   bit slave_en  = 1'b1;
   bit stray_ack = 1'b0;
   int scnt      = 0;

   initial begin
      forever begin
         @(negedge clk);
         if (bus_ack) begin
            bus_ack = 1'b0;
            scnt    = 0;
         end else if (bus_req === 1'b1 && slave_en) begin
            scnt++;
            if (scnt >= slave_lat) begin
               bus_ack   = 1'b1;
               bus_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : '0;
            end
         end else begin
            scnt = 0;
            if (stray_ack) begin
               bus_ack   = 1'b1;
               bus_rdata = 32'hBAD0BAD0;
               stray_ack = 1'b0;
            end
         end
      end
   end

   // ---------------- response monitor ----------------
   task automatic take(input bit is_mem, input logic [31:0] rdata);
      resp_t e;
      if (resp_q.size() == 0) begin
         check(is_mem ? "mem_rdy unexpected (queue size)" : "if_rdy unexpected (queue size)",
               resp_q.size(), 1);
      end else begin
         e = resp_q.pop_front();
         check("rdy side", is_mem, e.is_mem);
         if (e.chk_data) check(is_mem ? "mem_rdata" : "if_rdata", rdata, e.rdata);
         check("bus_err at rdy", bus_err, e.err);
      end
   endtask

   always @(negedge clk) begin
      if (if_rdy === 1'b1)  take(1'b0, if_rdata);
      if (mem_rdy === 1'b1) take(1'b1, mem_rdata);
   end

   // ---------------- bus command monitor ----------------
   bit   bus_prev   = 1'b0;
   bus_t bus_hold;
   int   bus_hi_cnt = 0;

   always @(negedge clk) begin
      if (bus_req === 1'b1) bus_hi_cnt++;
      if (bus_req === 1'b1 && !bus_prev) begin
         if (bus_q.size() == 0) begin
            check("bus_req unexpected (queue size)", bus_q.size(), 1);
         end else begin
            bus_hold = bus_q.pop_front();
            check("bus_addr", bus_addr, bus_hold.addr);
            check("bus_we", bus_we, bus_hold.we);
            check("bus_sel", bus_sel, bus_hold.sel);
            check("bus_wdata", bus_wdata, bus_hold.wdata);
         end
      end else if (bus_req === 1'b1) begin
         check("bus hold stable", {bus_we, bus_sel, bus_addr, bus_wdata},
               {bus_hold.we, bus_hold.sel, bus_hold.addr, bus_hold.wdata});
      end
      bus_prev = (bus_req === 1'b1);
   end

   // ---------------- stimulus ----------------
   // Issue n_if fetches and n_mem data accesses; each req is held until its
   // rdy is seen, then re-armed while transactions remain on that side.
   task automatic run_txn(input int n_if, input int n_mem, input int lat, input int budget);
      int cyc = 0;
      @(posedge clk); #1;
      slave_lat = lat;
      if_req    = (n_if > 0);
      mem_req   = (n_mem > 0);
      while ((n_if > 0 || n_mem > 0) && cyc < budget) begin
         @(negedge clk);
         cyc++;
         check("stallreq_if", stallreq_if, if_req & ~if_rdy);
         check("stallreq_mem", stallreq_mem, mem_req & ~mem_rdy);
         if (if_rdy && n_if > 0)   n_if--;
         if (mem_rdy && n_mem > 0) n_mem--;
         @(posedge clk); #1;
         if (n_if == 0)  if_req  = 1'b0;
         if (n_mem == 0) mem_req = 1'b0;
      end
      check("run_txn outstanding after budget", n_if + n_mem, 0);
      if_req  = 1'b0;
      mem_req = 1'b0;
      @(negedge clk);
      check("rdy pulse width", {if_rdy, mem_rdy}, 2'b00);
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1; rst = 1'b1;
      @(posedge clk); #1; rst = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL global time limit reached");
      $fatal(1);
   end

   initial begin
      bit seen;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset bus cmd", {bus_req, bus_we, bus_sel, bus_addr, bus_wdata}, '0);
      check("reset rdy", {if_rdy, mem_rdy, bus_err}, '0);
      check("reset rdata", {if_rdata, mem_rdata}, '0);
      check("reset stall", {stallreq_if, stallreq_mem}, '0);
      @(posedge clk); #1; rst = 1'b0;

      // 1: single fetch, ack two cycles after bus_req
      if_addr = 32'h100;
      push_bus(32'h100, 1'b0, 4'hF, 32'h0);
      push_resp(1'b0, 32'h24010005, 1'b1, 1'b0);
      rd_q.push_back(32'h24010005);
      run_txn(1, 0, 2, 30);

      // 2: lone store; IF side untouched
      mem_we = 1'b1; mem_sel = 4'h3; mem_addr = 32'h2000; mem_wdata = 32'hDEADBEEF;
      push_bus(32'h2000, 1'b1, 4'h3, 32'hDEADBEEF);
      push_resp(1'b1, 32'h0, 1'b0, 1'b0);
      rd_q.push_back(32'h0);
      run_txn(0, 1, 1, 30);
      check("if_rdata untouched by store", if_rdata, 32'h24010005);
      mem_we = 1'b0; mem_sel = 4'hF; mem_wdata = 32'h0;

      // 3: continuous conflict from reset: MEM, IF, MEM, IF
      pulse_reset();
      mem_addr = 32'h3000; if_addr = 32'h104;
      push_bus(32'h3000, 1'b0, 4'hF, 32'h0); push_resp(1'b1, 32'hAAAA0001, 1'b1, 1'b0);
      push_bus(32'h104,  1'b0, 4'hF, 32'h0); push_resp(1'b0, 32'h11110002, 1'b1, 1'b0);
      push_bus(32'h3000, 1'b0, 4'hF, 32'h0); push_resp(1'b1, 32'hAAAA0003, 1'b1, 1'b0);
      push_bus(32'h104,  1'b0, 4'hF, 32'h0); push_resp(1'b0, 32'h11110004, 1'b1, 1'b0);
      rd_q.push_back(32'hAAAA0001); rd_q.push_back(32'h11110002);
      rd_q.push_back(32'hAAAA0003); rd_q.push_back(32'h11110004);
      run_txn(2, 2, 1, 60);

      // 4a: flush while IF_BUSY -> bus completes, no if_rdy
      if_addr = 32'h300; slave_lat = 3;
      push_bus(32'h300, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h55555555);
      @(posedge clk); #1; if_req = 1'b1;
      @(posedge clk); #1; if_req = 1'b0; if_flush = 1'b1;
      @(posedge clk); #1; if_flush = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("if_rdata after busy flush", if_rdata, 32'h11110004);
      check("bus_req idle after busy flush", bus_req, 1'b0);

      // 4b: flush in the grant cycle
      if_addr = 32'h400; slave_lat = 2;
      push_bus(32'h400, 1'b0, 4'hF, 32'h0);
      rd_q.push_back(32'h66666666);
      if_req = 1'b1; if_flush = 1'b1;
      @(posedge clk); #1; if_req = 1'b0; if_flush = 1'b0;
      repeat (8) @(posedge clk);
      #1;
      check("if_rdata after grant flush", if_rdata, 32'h11110004);

      // 4c: following fetch completes normally
      if_addr = 32'h200;
      push_bus(32'h200, 1'b0, 4'hF, 32'h0);
      push_resp(1'b0, 32'h8C220004, 1'b1, 1'b0);
      rd_q.push_back(32'h8C220004);
      run_txn(1, 0, 1, 30);

      // 5: mem_req withdrawn mid-BUSY still completes
      mem_addr = 32'h3004; slave_lat = 4;
      push_bus(32'h3004, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h77777777, 1'b1, 1'b0);
      rd_q.push_back(32'h77777777);
      @(posedge clk); #1; mem_req = 1'b1;
      @(posedge clk); #1; mem_req = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 20 && !seen; c++) begin
         @(negedge clk);
         if (mem_rdy) seen = 1'b1;
      end
      check("withdrawn mem_req completes", seen, 1'b1);

`ifdef ARB_TIMEOUT_EN
      // 6: no ack -> watchdog ends the access after TO_CYC busy cycles
      slave_en = 1'b0;
      mem_addr = 32'h50;
      push_bus(32'h50, 1'b0, 4'hF, 32'h0);
      push_resp(1'b1, 32'h0, 1'b1, 1'b1);
      bus_hi_cnt = 0;
      run_txn(0, 1, 1, 40);
      check("timeout busy cycles", bus_hi_cnt, 8);
      check("mem_rdata after timeout", mem_rdata, 32'h0);
      slave_en = 1'b1;
`endif

      // 7: ack outside BUSY is ignored
      @(posedge clk); #1; stray_ack = 1'b1;
      repeat (4) @(negedge clk);
      check("stray ack: bus_req", bus_req, 1'b0);
      check("stray ack: rdata held", {if_rdata, mem_rdata},
            {32'h8C220004, mem_rdata_exp()});

      // 8: async reset in MEM_BUSY drops bus_req immediately
      slave_en = 1'b0;
      mem_addr = 32'h40;
      push_bus(32'h40, 1'b0, 4'hF, 32'h0);
      @(posedge clk); #1; mem_req = 1'b1;
      repeat (3) @(posedge clk);
      #2 rst = 1'b1;
      #1;
      check("reset mid-busy: bus_req", bus_req, 1'b0);
      check("reset mid-busy: rdy", {if_rdy, mem_rdy}, 2'b00);
      check("reset mid-busy: mem_rdata", mem_rdata, 32'h0);
      mem_req = 1'b0;
      @(posedge clk); #1; rst = 1'b0; slave_en = 1'b1;
      repeat (3) @(negedge clk);
      check("after reset: bus_req idle", bus_req, 1'b0);
      if_addr = 32'h180;
      push_bus(32'h180, 1'b0, 4'hF, 32'h0);
      push_resp(1'b0, 32'h3C1C0180, 1'b1, 1'b0);
      rd_q.push_back(32'h3C1C0180);
      run_txn(1, 0, 1, 30);

      repeat (3) @(negedge clk);
      check("resp_q leftover", resp_q.size(), 0);
      check("bus_q leftover", bus_q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Load data last delivered to MEM before the stray-ack step: a timed-out
   // access returns zero, otherwise the withdrawn-request load's data.
   function automatic logic [31:0] mem_rdata_exp();
`ifdef ARB_TIMEOUT_EN
      return 32'h0;
`else
      return 32'h77777777;
`endif
   endfunction

endmodule
